// File: rtl/soc_reset_pkg.sv
// Shared types and constants for the SoC reset sequencer and its debounce helper.
package soc_reset_pkg;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    BUS_UP = 2'd1,
    RUN    = 2'd2
  } rst_state_e;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;
endpackage

// File: rtl/soc_reset_ctrl_if.sv
// Button/software-request inputs and staged reset/status outputs of the reset sequencer.
interface soc_reset_ctrl_if;
  logic       btn_n_i;
  logic       sw_rst_req_i;
  logic       periph_rst_o;
  logic       cpu_rst_o;
  logic       ready_o;
  logic [1:0] rst_cause_o;
  logic [7:0] rst_count_o;

  modport master (
    output btn_n_i, sw_rst_req_i,
    input  periph_rst_o, cpu_rst_o, ready_o, rst_cause_o, rst_count_o
  );

  modport slave (
    input  btn_n_i, sw_rst_req_i,
    output periph_rst_o, cpu_rst_o, ready_o, rst_cause_o, rst_count_o
  );
endinterface

// File: rtl/reset_debounce.sv
// Two-flop synchroniser plus debounce for an active-low gpio input.
// press_o pulses in the same cycle stable_o falls, so a trigger can act on that edge.
module reset_debounce
  import soc_reset_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic reset,
  input  logic din_i,
  output logic stable_o,
  output logic press_o
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign accept = (sync2_q != stable_q) && (cnt_q == DEBOUNCE_CYCLES - CNT_W'(1));

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (accept) stable_d = sync2_q;
      else        cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = accept & stable_q;

endmodule

// File: rtl/soc_reset_ctrl.sv
// Reset sequencer: merges debounced button and CPU software request, releases
// peripheral reset first and CPU reset STAGGER_CYCLES later, tracks cause and count.
module soc_reset_ctrl
  import soc_reset_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [CNT_W-1:0] HOLD_CYCLES     = 16'd64,
  parameter logic [CNT_W-1:0] STAGGER_CYCLES  = 16'd16
) (
  input logic             clock,
  input logic             reset,
  soc_reset_ctrl_if.slave bus
);

  logic             btn_stable, btn_press, trigger;
  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             periph_q, cpu_q, ready_q;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       count_q, count_d;

  reset_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .din_i    (bus.btn_n_i),
    .stable_o (btn_stable),
    .press_o  (btn_press)
  );

  // A button press wins the cause when it coincides with a software request.
  assign trigger = btn_press | bus.sw_rst_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    cause_d = cause_q;
    count_d = count_q;
    if (trigger) begin
      cause_d = btn_press ? CAUSE_BTN : CAUSE_SW;
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end
    case (state_q)
      ASSERT: begin
        if (trigger || !btn_stable) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_CYCLES - CNT_W'(1)) begin
          state_d = BUS_UP;
          cnt_d   = '0;
        end
      end
      BUS_UP: begin
        if (trigger) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end else if (cnt_q == STAGGER_CYCLES - CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (trigger) state_d = ASSERT;
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ASSERT;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      ready_q  <= 1'b0;
      cause_q  <= CAUSE_POR;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= (state_d == ASSERT);
      cpu_q    <= (state_d != RUN);
      ready_q  <= (state_d == RUN);
      cause_q  <= cause_d;
      count_q  <= count_d;
    end
  end

  assign bus.periph_rst_o = periph_q;
  assign bus.cpu_rst_o    = cpu_q;
  assign bus.ready_o      = ready_q;
  assign bus.rst_cause_o  = cause_q;
  assign bus.rst_count_o  = count_q;

endmodule

// File: tb/tb_soc_reset_ctrl.sv
// Bench for soc_reset_ctrl with small timing parameters; a per-cycle behavioural
// model is compared against every output after each clock edge.
module tb_soc_reset_ctrl;
  localparam int DEB = 4;
  localparam int HOLD = 8;
  localparam int STAG = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  soc_reset_ctrl_if bus ();

  soc_reset_ctrl #(
    .DEBOUNCE_CYCLES (16'd4),
    .HOLD_CYCLES     (16'd8),
    .STAGGER_CYCLES  (16'd4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model state: raw sample history, debounced level, disagreement run,
  // cycles since the last blocking event, cause and trigger count.
  bit hist[$];
  bit m_stable;
  int m_run;
  int m_quiet;
  int m_cause;
  int m_count;

  task automatic model_reset();
    hist = '{1'b1, 1'b1};
    m_stable = 1'b1;
    m_run = 0;
    m_quiet = 0;
    m_cause = 0;
    m_count = 0;
  endtask

  task automatic model_edge(input bit raw, input bit sw);
    bit syn, old_stable, press, trig;
    hist.push_front(raw);
    syn = hist[2];
    void'(hist.pop_back());
    old_stable = m_stable;
    press = 1'b0;
    if (syn != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = syn;
        m_run = 0;
        press = (syn == 1'b0);
      end
    end else begin
      m_run = 0;
    end
    trig = press || sw;
    if (trig) begin
      m_cause = press ? 1 : 2;
      if (m_count < 255) m_count++;
    end
    if (trig || !old_stable) m_quiet = 0;
    else if (m_quiet < 10000) m_quiet++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("periph_rst", int'(bus.periph_rst_o), (m_quiet < HOLD) ? 1 : 0);
    chk("cpu_rst",    int'(bus.cpu_rst_o),    (m_quiet < HOLD + STAG) ? 1 : 0);
    chk("ready",      int'(bus.ready_o),      (m_quiet < HOLD + STAG) ? 0 : 1);
    chk("cause",      int'(bus.rst_cause_o),  m_cause);
    chk("count",      int'(bus.rst_count_o),  m_count);
  endtask

  task automatic tick();
    bit raw, sw;
    raw = bus.btn_n_i;
    sw  = bus.sw_rst_req_i;
    @(posedge clock);
    #1;
    if (!reset) model_edge(raw, sw);
    compare();
  endtask

  initial begin
    bus.btn_n_i = 1'b1;
    bus.sw_rst_req_i = 1'b0;
    model_reset();

    // Power-on reset held for three cycles.
    for (int i = 0; i < 3; i++) tick();
    chk("por_hold_periph", int'(bus.periph_rst_o), 1);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 7)  chk("por_periph_e7", int'(bus.periph_rst_o), 1);
      if (i == 8)  chk("por_periph_e8", int'(bus.periph_rst_o), 0);
      if (i == 11) chk("por_cpu_e11", int'(bus.cpu_rst_o), 1);
      if (i == 12) begin
        chk("por_cpu_e12", int'(bus.cpu_rst_o), 0);
        chk("por_ready_e12", int'(bus.ready_o), 1);
      end
    end

    // Three-cycle glitch must be rejected.
    bus.btn_n_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.btn_n_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("glitch_count", int'(bus.rst_count_o), 0);
    chk("glitch_periph", int'(bus.periph_rst_o), 0);

    // Twenty-cycle button press.
    bus.btn_n_i = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 20) bus.btn_n_i = 1'b1;
      if (i == 5)  chk("btn_periph_e5", int'(bus.periph_rst_o), 0);
      if (i == 6)  begin
        chk("btn_periph_e6", int'(bus.periph_rst_o), 1);
        chk("btn_cpu_e6", int'(bus.cpu_rst_o), 1);
      end
      if (i == 33) chk("btn_periph_e33", int'(bus.periph_rst_o), 1);
      if (i == 34) chk("btn_periph_e34", int'(bus.periph_rst_o), 0);
      if (i == 37) chk("btn_ready_e37", int'(bus.ready_o), 0);
      if (i == 38) chk("btn_ready_e38", int'(bus.ready_o), 1);
    end
    chk("btn_cause", int'(bus.rst_cause_o), 1);
    chk("btn_count", int'(bus.rst_count_o), 1);

    // One-cycle software request.
    bus.sw_rst_req_i = 1'b1;
    tick();
    bus.sw_rst_req_i = 1'b0;
    chk("sw_periph_e1", int'(bus.periph_rst_o), 1);
    for (int i = 2; i <= 16; i++) begin
      tick();
      if (i == 12) chk("sw_ready_e12", int'(bus.ready_o), 0);
      if (i == 13) chk("sw_ready_e13", int'(bus.ready_o), 1);
    end
    chk("sw_cause", int'(bus.rst_cause_o), 2);
    chk("sw_count", int'(bus.rst_count_o), 2);

    // Press event coinciding with a software request.
    bus.btn_n_i = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      bus.sw_rst_req_i = (i == 6);
      if (i == 21) bus.btn_n_i = 1'b1;
      tick();
      if (i == 6) begin
        chk("both_cause", int'(bus.rst_cause_o), 1);
        chk("both_count", int'(bus.rst_count_o), 3);
      end
    end
    bus.sw_rst_req_i = 1'b0;
    chk("both_ready", int'(bus.ready_o), 1);

    // 255 further triggers saturate the counter; CPU stays in reset meanwhile.
    bus.sw_rst_req_i = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i == 200) chk("sat_cpu_held", int'(bus.cpu_rst_o), 1);
    end
    bus.sw_rst_req_i = 1'b0;
    chk("sat_count", int'(bus.rst_count_o), 255);
    chk("sat_model", m_count, 255);

    // Async reset in BUS_UP.
    for (int i = 0; i < 10; i++) tick();
    chk("bus_up_periph", int'(bus.periph_rst_o), 0);
    chk("bus_up_cpu", int'(bus.cpu_rst_o), 1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_periph", int'(bus.periph_rst_o), 1);
    chk("async_cause", int'(bus.rst_cause_o), 0);
    chk("async_count", int'(bus.rst_count_o), 0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 8)  chk("rpor_periph_e8", int'(bus.periph_rst_o), 0);
      if (i == 12) chk("rpor_ready_e12", int'(bus.ready_o), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
